// File: rtl/piso_ctrl_pkg.sv
// Shared types and constants for the piso_tx_ctrl shift-register sequencer.
package piso_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    DONE   = 3'd4
  } piso_ctrl_state_e;

  // Shift register mode encoding on piso_ls_o.
  localparam logic PISO_LOAD  = 1'b1;
  localparam logic PISO_SHIFT = 1'b0;

endpackage

// File: rtl/piso_tx_ctrl_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + TW'(1);
    end
  end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Sequencer for an LSB-first PISO shift register: handshake capture, load/shift
// pulses, bit stretching and framing. Optional parity bit: PISO_CTRL_PARITY_EN.
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int DW           = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] piso_data_o,
  output logic          piso_enb_o,
  output logic          piso_ls_o,
  output logic          frame_o,
  output logic          busy_o,
  output logic          done_o
`ifdef PISO_CTRL_PARITY_EN
  ,
  output logic          parity_o,
  output logic          par_sel_o
`endif
);

  localparam int BW = $clog2(DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  piso_ctrl_state_e state, state_n;
  logic [BW-1:0]    bit_cnt;
  logic             timer_en;
  logic             tick;

  assign timer_en = (state == SHIFT) || (state == PARITY);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!timer_en),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The bit counter only runs in SHIFT, so it is already zero on LOAD -> SHIFT.
  always_ff @(posedge clk) begin
    if (rst || (state != SHIFT)) begin
      bit_cnt <= '0;
    end else if (tick) begin
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      piso_data_o <= '0;
    end else if ((state == IDLE) && valid_i) begin
      piso_data_o <= data_i;
    end
  end

`ifdef PISO_CTRL_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_o <= 1'b0;
    end else if ((state == IDLE) && valid_i) begin
      parity_o <= ^data_i;
    end
  end

  assign par_sel_o = (state == PARITY);
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    ready_o    = 1'b0;
    busy_o     = 1'b1;
    frame_o    = 1'b0;
    done_o     = 1'b0;
    piso_enb_o = 1'b0;
    piso_ls_o  = PISO_SHIFT;

    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (valid_i) state_n = LOAD;
      end
      LOAD: begin
        piso_enb_o = 1'b1;
        piso_ls_o  = PISO_LOAD;
        state_n    = SHIFT;
      end
      SHIFT: begin
        frame_o    = 1'b1;
        piso_enb_o = tick;
        if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef PISO_CTRL_PARITY_EN
          state_n = PARITY;
`else
          state_n = DONE;
`endif
        end
      end
      PARITY: begin
        // The line is driven from parity_o here; the shift register idles.
        frame_o = 1'b1;
        if (tick) state_n = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: CPB=1 and CPB=3 instances, each driving a
// model of the LSB-first shift register. Compile with PISO_CTRL_PARITY_EN for parity.
module tb_piso_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: CLKS_PER_BIT = 1
  logic       valid_a = 1'b0;
  logic [3:0] data_a = '0;
  logic       ready_a, enb_a, ls_a, frame_a, busy_a, done_a;
  logic [3:0] pd_a;
  logic       par_a, psel_a;

  // Instance B: CLKS_PER_BIT = 3
  logic       valid_b = 1'b0;
  logic [3:0] data_b = '0;
  logic       ready_b, enb_b, ls_b, frame_b, busy_b, done_b;
  logic [3:0] pd_b;
  logic       par_b, psel_b;

  piso_tx_ctrl #(.DW(4), .CLKS_PER_BIT(1)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_a),
    .valid_i     (valid_a),
    .ready_o     (ready_a),
    .piso_data_o (pd_a),
    .piso_enb_o  (enb_a),
    .piso_ls_o   (ls_a),
    .frame_o     (frame_a),
    .busy_o      (busy_a),
    .done_o      (done_a)
`ifdef PISO_CTRL_PARITY_EN
    ,
    .parity_o    (par_a),
    .par_sel_o   (psel_a)
`endif
  );

  piso_tx_ctrl #(.DW(4), .CLKS_PER_BIT(3)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_b),
    .valid_i     (valid_b),
    .ready_o     (ready_b),
    .piso_data_o (pd_b),
    .piso_enb_o  (enb_b),
    .piso_ls_o   (ls_b),
    .frame_o     (frame_b),
    .busy_o      (busy_b),
    .done_o      (done_b)
`ifdef PISO_CTRL_PARITY_EN
    ,
    .parity_o    (par_b),
    .par_sel_o   (psel_b)
`endif
  );

`ifdef PISO_CTRL_PARITY_EN
  localparam int GAP_A = 4 * 1 + 3 + 1;
  localparam int FRAME_B = 4 * 3 + 3;
`else
  assign par_a  = 1'b0;
  assign psel_a = 1'b0;
  assign par_b  = 1'b0;
  assign psel_b = 1'b0;
  localparam int GAP_A = 4 * 1 + 3;
  localparam int FRAME_B = 4 * 3;
`endif

  // Shift register models: load on enb&ls, shift right (LSB out) on enb&!ls.
  logic [3:0] sr_a, sr_b;
  always @(posedge clk) begin
    if (rst) sr_a <= '0;
    else if (enb_a) sr_a <= ls_a ? pd_a : {1'b0, sr_a[3:1]};
  end
  always @(posedge clk) begin
    if (rst) sr_b <= '0;
    else if (enb_b) sr_b <= ls_b ? pd_b : {1'b0, sr_b[3:1]};
  end

  // {ready, busy, frame, done, enb, ls}
  function automatic logic [5:0] st_a();
    return {ready_a, busy_a, frame_a, done_a, enb_a, ls_a};
  endfunction
  function automatic logic [5:0] st_b();
    return {ready_b, busy_b, frame_b, done_b, enb_b, ls_b};
  endfunction

  localparam logic [5:0] ST_IDLE  = 6'b100000;
  localparam logic [5:0] ST_LOAD  = 6'b010011;
  localparam logic [5:0] ST_SHIFT = 6'b011010;
  localparam logic [5:0] ST_DONE  = 6'b010100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word through instance A, checking every cycle from LOAD to IDLE.
  task automatic send_a(input logic [3:0] d, input logic exp_par);
    valid_a = 1'b1;
    data_a  = d;
    step();
    valid_a = 1'b0;
    data_a  = 4'h0;
    check("load_status", 32'(st_a()), 32'(ST_LOAD));
    check("load_data", 32'(pd_a), 32'(d));
`ifdef PISO_CTRL_PARITY_EN
    check("parity_bit", 32'(par_a), 32'(exp_par));
`endif
    for (int k = 0; k < 4; k++) begin
      step();
      check("shift_status", 32'(st_a()), 32'(ST_SHIFT));
      check("serial_bit", 32'(sr_a[0]), 32'(d[k]));
    end
`ifdef PISO_CTRL_PARITY_EN
    step();
    check("parity_period", 32'({psel_a, frame_a, enb_a, done_a}), 32'(4'b1100));
`endif
    step();
    check("done_status", 32'(st_a()), 32'(ST_DONE));
    step();
    check("ready_after", 32'(st_a()), 32'(ST_IDLE));
    check("par_sel_idle", 32'(psel_a), 32'd0);
    if (exp_par === 1'bx) check("unused", 32'd0, 32'd1);
  endtask

  initial begin
    int nf, npulse, ndone, loads, nbit;
    int lc[2];
    logic [3:0] eb;
    logic [7:0] rx;

    // Reset, then ten idle cycles on both instances.
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_idle_a", 32'({st_a(), pd_a, par_a, psel_a}), 32'({ST_IDLE, 4'h0, 2'b00}));
      check("rst_idle_b", 32'({st_b(), pd_b, par_b, psel_b}), 32'({ST_IDLE, 4'h0, 2'b00}));
    end

    // Single word, CPB=1: bits 1,1,0,1.
    send_a(4'b1011, 1'b1);

    // Bit stretching, CPB=3, 4'b0110.
    eb = 4'b0110;
    nf = 0; npulse = 0; ndone = 0;
    valid_b = 1'b1;
    data_b  = eb;
    step();
    valid_b = 1'b0;
    check("b_load_status", 32'(st_b()), 32'(ST_LOAD));
    for (int i = 0; i < 20; i++) begin
      step();
      if (frame_b && !psel_b) begin
        check("b_serial", 32'(sr_b[0]), 32'(eb[nf / 3]));
        check("b_shift_pulse", 32'(enb_b), 32'((nf % 3) == 2));
      end
      if (frame_b) nf++;
      if (enb_b && !ls_b) npulse++;
      if (done_b) ndone++;
    end
    check("b_frame_cycles", 32'(nf), 32'(FRAME_B));
    check("b_shift_pulses", 32'(npulse), 32'd4);
    check("b_done_count", 32'(ndone), 32'd1);
    check("b_idle_after", 32'(st_b()), 32'(ST_IDLE));

    // Back-to-back with valid held high: 4'hA then 4'h5.
    loads = 0; nbit = 0; ndone = 0; rx = '0;
    lc[0] = 0; lc[1] = 0;
    valid_a = 1'b1;
    data_a  = 4'hA;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      step();
      if (enb_a && ls_a) begin
        if (loads < 2) lc[loads] = cyc;
        loads++;
        if (loads == 1) data_a = 4'h5;
        else valid_a = 1'b0;
      end
      if (frame_a && !psel_a && nbit < 8) begin
        rx[nbit] = sr_a[0];
        nbit++;
      end
      if (done_a) ndone++;
    end
    valid_a = 1'b0;
    check("b2b_loads", 32'(loads), 32'd2);
    check("b2b_gap", 32'(lc[1] - lc[0]), 32'(GAP_A));
    check("b2b_bits", 32'(nbit), 32'd8);
    check("b2b_words", 32'(rx), 32'h5A);
    check("b2b_dones", 32'(ndone), 32'd2);
    step();
    check("b2b_idle", 32'(st_a()), 32'(ST_IDLE));

    // Reset during bit 2 of 4'hF.
    valid_a = 1'b1;
    data_a  = 4'hF;
    step();
    valid_a = 1'b0;
    step();
    step();
    step();
    check("mid_bit2_on_line", 32'({frame_a, sr_a[0]}), 32'(2'b11));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_status", 32'(st_a()), 32'(ST_IDLE));
    check("mid_rst_data", 32'(pd_a), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_done", 32'({done_a, busy_a}), 32'd0);
    end
    send_a(4'h3, 1'b0);

    // Parity word (parity checks active when PISO_CTRL_PARITY_EN is defined).
    send_a(4'b0111, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
